lap_store_slave: RTL and testbench

//  Wishbone classic responder on the chronometer bus (slave port behind wb_conbus_top).

---
 rtl/lap_store_slave_pkg.sv | 30 +++
 rtl/lap_store_slave_lap_fifo.sv | 83 ++++++++
 rtl/lap_store_slave.sv | 132 +++++++++++++
 tb/tb_lap_store_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lap_store_slave_pkg.sv
// Register map, STATUS bit positions and a status packing helper shared by the
// lap store slave and its bus master.
package lap_store_slave_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_PUSH   = 2'd1;
  localparam logic [1:0] REG_POP    = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;
  localparam int         PEEK_BIT   = 6;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 3;

  localparam int WR_FLUSH     = 0;
  localparam int WR_CLR_FLAGS = 1;

  function automatic logic [3:0] status_bits(input logic unf, input logic ovf,
                                             input logic full, input logic empty);
    logic [3:0] s;
    s               = '0;
    s[ST_UNDERFLOW] = unf;
    s[ST_OVERFLOW]  = ovf;
    s[ST_FULL]      = full;
    s[ST_EMPTY]     = empty;
    return s;
  endfunction

endpackage

// File: rtl/lap_store_slave_lap_fifo.sv
// Circular lap buffer with push/pop/flush and a random-access peek port.
// LAP_STORE_OVERWRITE_EN: a push into a full buffer replaces the oldest entry.
module lap_fifo #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic [ADDR_SIZE-1:0] peek_idx_i,
  output logic [DATA_SIZE-1:0] head_data_o,
  output logic [DATA_SIZE-1:0] peek_data_o,
  output logic [ADDR_SIZE:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_CNT = DEPTH[ADDR_SIZE:0];
`ifdef LAP_STORE_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [ADDR_SIZE-1:0] head_q, head_d, tail_q, tail_d, peek_ptr;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic                 wr_en;

  assign full_o      = (count_q == FULL_CNT);
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_data_o = mem_q[head_q];
  assign peek_ptr    = head_q + peek_idx_i;
  assign peek_data_o = ({1'b0, peek_idx_i} < count_q) ? mem_q[peek_ptr] : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (push_i) begin
      if (!full_o) begin
        wr_en   = 1'b1;
        tail_d  = tail_q + 1'b1;
        count_d = count_q + 1'b1;
      end else if (OVERWRITE) begin
        // Oldest entry sits at tail when full; overwrite it and slide both pointers.
        wr_en  = 1'b1;
        tail_d = tail_q + 1'b1;
        head_d = head_q + 1'b1;
      end
    end else if (pop_i && !empty_o) begin
      head_d  = head_q + 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[tail_q] <= wdata_i;
  end

endmodule

// File: rtl/lap_store_slave.sv
// Wishbone classic slave storing lap times in a circular buffer (push/pop/peek).
// Full-buffer push policy selected by LAP_STORE_OVERWRITE_EN (see lap_fifo).
module lap_store_slave
  import lap_store_slave_pkg::*;
#(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 11,
  parameter int GRANULARITY   = 8,
  parameter int ADDR_SIZE     = 4,
  parameter int DATA_SIZE     = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [WB_ADDR_WIDTH-1:0]               addr_i,
  input  logic [WB_DATA_WIDTH-1:0]               data_i,
  output logic [WB_DATA_WIDTH-1:0]               data_o,
  input  logic [WB_DATA_WIDTH/GRANULARITY-1:0]   sel_i,
  input  logic                                   stb_i,
  input  logic                                   cyc_i,
  input  logic                                   we_i,
  output logic                                   ack_o,
  output logic                                   lap_avail_o
);

  localparam int SEL_W = WB_DATA_WIDTH / GRANULARITY;

  logic                     ack_q, ack_d, lap_avail_q, lap_avail_d;
  logic                     ovf_q, ovf_d, unf_q, unf_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d, wdat;
  logic                     accept, hi_zero, peek_hit, reg_hit;
  logic                     push, pop, flush, full, empty;
  logic [DATA_SIZE-1:0]     head_data, peek_data;
  logic [ADDR_SIZE:0]       count;
  logic                     unused_bits;

  always_comb begin
    wdat = '0;
    for (int l = 0; l < SEL_W; l++)
      wdat[l*GRANULARITY +: GRANULARITY] = sel_i[l] ? data_i[l*GRANULARITY +: GRANULARITY] : '0;
  end

  // A new access is only taken while no ack is outstanding, which also yields ack every other cycle on held strobes.
  assign accept   = cyc_i & stb_i & ~ack_q & ~rst_i;
  assign hi_zero  = (addr_i[WB_ADDR_WIDTH-1:PEEK_BIT+1] == '0);
  assign peek_hit = hi_zero & addr_i[PEEK_BIT];
  assign reg_hit  = hi_zero & ~addr_i[PEEK_BIT] & (addr_i[5:4] == 2'b00);
  assign unused_bits = ^{addr_i, wdat};

  always_comb begin
    ack_d       = 1'b0;
    dat_d       = '0;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    lap_avail_d = (count != '0);
    if (accept) begin
      ack_d = 1'b1;
      if (we_i) begin
        if (reg_hit && (sel_i != '0)) begin
          case (addr_i[3:2])
            REG_STATUS: begin
              flush = wdat[WR_FLUSH];
              if (wdat[WR_CLR_FLAGS]) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
              end
            end
            REG_PUSH: begin
              push = 1'b1;
              if (full) ovf_d = 1'b1;
            end
            default: ;
          endcase
        end
      end else if (peek_hit) begin
        dat_d[DATA_SIZE-1:0] = peek_data;
      end else if (reg_hit) begin
        case (addr_i[3:2])
          REG_STATUS: dat_d[3:0] = status_bits(unf_q, ovf_q, full, empty);
          REG_POP: begin
            pop = 1'b1;
            if (empty) unf_d = 1'b1;
            else       dat_d[DATA_SIZE-1:0] = head_data;
          end
          REG_COUNT:  dat_d[ADDR_SIZE:0] = count;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      lap_avail_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      lap_avail_q <= lap_avail_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign ack_o       = ack_q;
  assign data_o      = dat_q;
  assign lap_avail_o = lap_avail_q;

  lap_fifo #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (flush),
    .wdata_i     (wdat[DATA_SIZE-1:0]),
    .peek_idx_i  (addr_i[ADDR_SIZE+1:2]),
    .head_data_o (head_data),
    .peek_data_o (peek_data),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

endmodule

// File: tb/tb_lap_store_slave.sv
// Bench for lap_store_slave: directed steps plus random traffic against a queue model.
// Follows LAP_STORE_OVERWRITE_EN the same way the design does.
module tb_lap_store_slave;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [10:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [3:0]  sel_i = '0;
  logic        stb_i = 1'b0, cyc_i = 1'b0, we_i = 1'b0;
  logic        ack_o, lap_avail_o;

  int tests = 0;
  int fails = 0;

  logic [15:0] q[$];
  bit          m_ovf = 0, m_unf = 0;

  lap_store_slave dut (
    .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .we_i(we_i), .ack_o(ack_o),
    .lap_avail_o(lap_avail_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic we, input logic [10:0] addr, input logic [31:0] wd,
                    input logic [3:0] sel, output logic [31:0] rd);
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = we; addr_i = addr; data_i = wd; sel_i = sel;
    @(posedge clk); #1;
    check("ack_rise", {31'd0, ack_o}, 32'd1);
    rd = data_o;
    cyc_i = 0; stb_i = 0; we_i = 0;
    @(posedge clk); #1;
    check("ack_fall", {31'd0, ack_o}, 32'd0);
  endtask

  function automatic logic [31:0] m_status();
    return {28'd0, m_unf, m_ovf, q.size() == DEPTH, q.size() == 0};
  endfunction

  function automatic void m_push(input logic [15:0] v);
    if (q.size() == DEPTH) begin
      m_ovf = 1;
`ifdef LAP_STORE_OVERWRITE_EN
      void'(q.pop_front());
      q.push_back(v);
`endif
    end else q.push_back(v);
  endfunction

  function automatic logic [31:0] m_pop();
    if (q.size() == 0) begin
      m_unf = 1;
      return 32'd0;
    end
    return {16'd0, q.pop_front()};
  endfunction

  function automatic logic [31:0] m_peek(input int i);
    return (i < q.size()) ? {16'd0, q[i]} : 32'd0;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  task automatic push(input logic [31:0] v, input logic [3:0] sel);
    logic [31:0] rd, mv;
    wb(1, 11'h004, v, sel, rd);
    mv = v & lane_mask(sel);
    if (sel != 0) m_push(mv[15:0]);
  endtask

  task automatic rd_chk(input string tag, input logic [10:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    wb(0, addr, 32'd0, 4'hF, rd);
    check(tag, rd, exp);
  endtask

  task automatic status_wr(input logic [31:0] v, input logic [3:0] sel);
    logic [31:0] rd, mv;
    wb(1, 11'h000, v, sel, rd);
    mv = v & lane_mask(sel);
    if (mv[0]) q.delete();
    if (mv[1]) begin m_ovf = 0; m_unf = 0; end
  endtask

  initial begin
    logic [31:0] rd, v, exp;
    logic [3:0]  sel;
    int          idx;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_avail", {31'd0, lap_avail_o}, 32'd0);
    @(negedge clk); rst_i = 0;

    rd_chk("status_reset", 11'h000, 32'h1);

    // Held strobe: ack every other cycle
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = 0; addr_i = 11'h00C; sel_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("held_ack", {31'd0, ack_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    cyc_i = 0; stb_i = 0;
    @(posedge clk); #1;

    // Basic push / pop
    push(32'h0123, 4'hF);
    push(32'h0456, 4'hF);
    check("avail_after_push", {31'd0, lap_avail_o}, 32'd1);
    rd_chk("count2", 11'h00C, 32'd2);
    rd_chk("pop1", 11'h008, m_pop());
    rd_chk("pop2", 11'h008, m_pop());
    rd_chk("status_empty", 11'h000, 32'h1);
    check("avail_empty", {31'd0, lap_avail_o}, 32'd0);

    // Underflow and clear
    rd_chk("pop_empty", 11'h008, m_pop());
    rd_chk("status_unf", 11'h000, 32'h9);
    status_wr(32'h2, 4'hF);
    rd_chk("status_clr", 11'h000, 32'h1);

    // Fill past full with 1..17
    for (int k = 1; k <= 17; k++) push(k, 4'hF);
`ifdef LAP_STORE_OVERWRITE_EN
    exp = 32'd2;
`else
    exp = 32'd1;
`endif
    rd_chk("peek0_full", 11'h040, exp);
    rd_chk("peek15_full", 11'h040 | (15 << 2), m_peek(15));
    rd_chk("status_full_ovf", 11'h000, 32'h6);
    rd_chk("count_full", 11'h00C, 32'd16);
    status_wr(32'h3, 4'hF);
    rd_chk("status_flushed", 11'h000, 32'h1);

    // Peek does not consume; out-of-range peek is zero; flush
    for (int k = 0; k < 3; k++) push($urandom_range(0, 65535), 4'hF);
    rd_chk("peek1", 11'h044, m_peek(1));
    rd_chk("count_after_peek", 11'h00C, 32'd3);
    rd_chk("peek5_empty", 11'h054, 32'd0);
    status_wr(32'h1, 4'hF);
    rd_chk("count_after_flush", 11'h00C, 32'd0);

    // Byte lanes, zero sel, unmapped address
    push(32'hABCD, 4'b0001);
    rd_chk("peek_lane0", 11'h040, 32'h00CD);
    push(32'h1234, 4'b0000);
    rd_chk("count_sel0", 11'h00C, 32'd1);
    rd_chk("unmapped", 11'h010, 32'd0);
    rd_chk("push_reg_read", 11'h004, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          v = $urandom;
          sel = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
          push(v, sel);
        end
        2: rd_chk("rnd_pop", 11'h008, m_pop());
        3: begin
          idx = $urandom_range(0, DEPTH - 1);
          rd_chk("rnd_peek", 11'(11'h040 | (idx << 2)), m_peek(idx));
        end
        4: rd_chk("rnd_count", 11'h00C, q.size());
        default: begin
          if ($urandom_range(0, 3) == 0) status_wr($urandom_range(0, 3), 4'($urandom_range(0, 15)));
          else rd_chk("rnd_status", 11'h000, m_status());
        end
      endcase
      check("rnd_avail", {31'd0, lap_avail_o}, (q.size() != 0) ? 32'd1 : 32'd0);
    end

    // Reset while an ack is pending with 4 entries stored
    status_wr(32'h3, 4'hF);
    for (int k = 0; k < 4; k++) push(k + 100, 4'hF);
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = 0; addr_i = 11'h008; sel_i = 4'hF;
    @(posedge clk); #1;
    check("pre_rst_ack", {31'd0, ack_o}, 32'd1);
    rst_i = 1; cyc_i = 0; stb_i = 0;
    @(posedge clk); #1;
    check("rst_mid_ack", {31'd0, ack_o}, 32'd0);
    check("rst_mid_avail", {31'd0, lap_avail_o}, 32'd0);
    @(negedge clk); rst_i = 0;
    q.delete(); m_ovf = 0; m_unf = 0;
    rd_chk("count_after_rst", 11'h00C, 32'd0);
    rd_chk("status_after_rst", 11'h000, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
